// File: rtl/riscv_ifetch_queue_if.sv
// Fetch-unit boundary bundle: instruction-memory port, execute redirect, decode handshake.
// Latency: none (wires only).
// Backpressure: decode stalls the fetch unit through if_ready; the memory side has no stall.
//
// Signals
//   imem_req/imem_addr     : fetch unit -> instruction memory, word address
//   imem_rvalid/imem_rdata : instruction memory -> fetch unit, exactly 1 cycle after imem_req
//   br_en/br_target        : execute -> fetch unit, single-cycle redirect pulse
//   if_valid/if_ready      : fetch unit <-> decode handshake
//   if_ir/if_npc           : head instruction and its word-indexed next PC
//   fetch_err              : sticky protocol-error flag
//
// master = the fetch unit, slave = its environment (memory, execute, decode).
interface riscv_ifetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        br_en;
    logic [31:0] br_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_ir;
    logic [31:0] if_npc;
    logic        fetch_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        input  br_en,
        input  br_target,
        output if_valid,
        input  if_ready,
        output if_ir,
        output if_npc,
        output fetch_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        output br_en,
        output br_target,
        input  if_valid,
        output if_ready,
        input  if_ir,
        input  if_npc,
        input  fetch_err
    );
endinterface

// File: rtl/riscv_ifetch_queue.sv
// Instruction fetch front end: owns the PC, fetches words, buffers them in a DEPTH-entry prefetch queue.
// Latency: request at t, response at t+1, if_valid at t+2; redirect at r gives first new instruction at r+3.
// Backpressure: if_ready=0 lets the queue fill to DEPTH, after which imem_req stays low and the PC holds.
//
// Ports
//   clk  : pipeline clock, rising edge
//   RN   : asynchronous active-low reset
//   bus  : riscv_ifetch_queue_if.master (memory port, redirect, decode handshake, error flag)
module riscv_ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          CW       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   RN,
    riscv_ifetch_queue_if.master   bus
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // One queue entry: instruction word plus the word address following it.
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } entry_t;

    logic [31:0]   pc;
    logic [31:0]   addr_reg;    // fetch address of the single outstanding request
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;    // only ever 0 or 1 because memory latency is fixed at 1
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          fetch_err_q;
    logic          post_rst;    // high only during the first cycle after reset release

    entry_t        fifo_mem [DEPTH];
    entry_t        head;

    logic          req;
    logic          push;
    logic          pop;
    logic          spurious;
    logic          not_empty;
    logic [CW:0]   occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Handshake decode. A redirect suppresses request, push and pop in its cycle.
    // The request gate counts the outstanding fetch as already occupying a slot,
    // so a returning word always finds room.
    always_comb begin
        occupancy = {1'b0, count} + {1'b0, inflight};
        not_empty = (count != '0);
        req       = RN & ~bus.br_en & (occupancy < (CW+1)'(DEPTH));
        push      = bus.imem_rvalid & (inflight != '0) & ~bus.br_en;
        pop       = not_empty & ~bus.br_en & bus.if_ready;
        // A stray response is an error except when it is the tail of a
        // request issued before reset, or is being discarded by a redirect.
        spurious  = bus.imem_rvalid & (inflight == '0) & ~bus.br_en & ~post_rst;
    end

    always_comb begin
        head          = fifo_mem[rd_ptr];
        bus.imem_req  = req;
        bus.imem_addr = pc;
        bus.if_valid  = not_empty & ~bus.br_en;
        bus.if_ir     = not_empty ? head.ir  : 32'h0;
        bus.if_npc    = not_empty ? head.npc : 32'h0;
        bus.fetch_err = fetch_err_q;
    end

    // Control state.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            pc          <= RESET_PC;
            addr_reg    <= 32'h0;
            count       <= '0;
            inflight    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fetch_err_q <= 1'b0;
            post_rst    <= 1'b1;
        end else begin
            post_rst <= 1'b0;
            if (spurious) begin
                fetch_err_q <= 1'b1;
            end

            if (bus.br_en) begin
                pc       <= bus.br_target;
                count    <= '0;
                inflight <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req) begin
                    pc       <= pc + 32'd1;
                    addr_reg <= pc;
                end
                inflight <= CW'(req);

                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end

                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage needs no reset: entries are only read when count says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{ir: bus.imem_rdata, npc: addr_reg + 32'd1};
        end
    end

    // Structural invariants the request gate is meant to guarantee.
    a_no_push_on_full: assert property (@(posedge clk) disable iff (!RN)
        push |-> (count != CW'(DEPTH)));
    a_inflight_bound: assert property (@(posedge clk) disable iff (!RN)
        inflight <= CW'(1));
    a_count_bound: assert property (@(posedge clk) disable iff (!RN)
        count <= CW'(DEPTH));

endmodule

// File: tb/tb_riscv_ifetch_queue.sv
module tb_riscv_ifetch_queue;

    logic clk = 1'b0;
    logic RN;

    riscv_ifetch_queue_if bus();

    riscv_ifetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'd0)
    ) dut (
        .clk (clk),
        .RN  (RN),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } exp_t;

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ir;
        logic [31:0] npc;
    } vec_t;

    exp_t        sb[$];
    logic        pend_req;
    logic [31:0] pend_addr;
    logic        s_req, s_vld, s_err;
    logic [31:0] s_addr, s_ir, s_npc;

    vec_t va[6];
    vec_t vb[11];

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'h1000 + a;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] ir, input logic [31:0] npc);
        vec_t v;
        v.rdy = rdy; v.req = req; v.addr = addr; v.vld = vld; v.ir = ir; v.npc = npc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One pipeline cycle. Entered at posedge+1: drives inputs (memory response to last
    // cycle's request), samples outputs at the falling edge, runs the scoreboard, then
    // advances to posedge+1 of the next cycle.
    task automatic cycle(input logic rdy, input logic br, input logic [31:0] tgt, input logic spur);
        exp_t e;
        bus.imem_rvalid = pend_req | spur;
        bus.imem_rdata  = pend_req ? imem_word(pend_addr) : 32'hDEAD_BEEF;
        bus.if_ready    = rdy;
        bus.br_en       = br;
        bus.br_target   = tgt;
        #4;
        s_req  = bus.imem_req;
        s_addr = bus.imem_addr;
        s_vld  = bus.if_valid;
        s_ir   = bus.if_ir;
        s_npc  = bus.if_npc;
        s_err  = bus.fetch_err;
        if (br) begin
            sb.delete();
        end else begin
            if (s_vld && rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_pop actual=%h expected=no_instruction", s_ir);
                end else begin
                    e = sb.pop_front();
                    check("sb_ir", s_ir, e.ir);
                    check("sb_npc", s_npc, e.npc);
                end
            end
            if (s_req) sb.push_back('{ir: imem_word(s_addr), npc: s_addr + 32'd1});
        end
        pend_req  = s_req;
        pend_addr = s_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.br_en       = 1'b0;
        bus.br_target   = 32'h0;
        bus.if_ready    = 1'b0;
        pend_req        = 1'b0;
        pend_addr       = 32'h0;
        sb.delete();
    endtask

    // Leaves time at posedge+1 with RN just released: the next cycle() is cycle 0.
    task automatic do_reset();
        RN = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        RN = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int idx);
        cycle(v.rdy, 1'b0, 32'h0, 1'b0);
        check($sformatf("%s[%0d].req", tag, idx),  32'(s_req), 32'(v.req));
        if (v.req) check($sformatf("%s[%0d].addr", tag, idx), s_addr, v.addr);
        check($sformatf("%s[%0d].vld", tag, idx),  32'(s_vld), 32'(v.vld));
        check($sformatf("%s[%0d].ir", tag, idx),   s_ir,  v.ir);
        check($sformatf("%s[%0d].npc", tag, idx),  s_npc, v.npc);
    endtask

    initial begin
        // Streaming with if_ready=1: first instruction at cycle 2, then one per cycle.
        va[0] = mk(1'b1, 1'b1, 32'd0, 1'b0, 32'h0,    32'd0);
        va[1] = mk(1'b1, 1'b1, 32'd1, 1'b0, 32'h0,    32'd0);
        va[2] = mk(1'b1, 1'b1, 32'd2, 1'b1, 32'h1000, 32'd1);
        va[3] = mk(1'b1, 1'b1, 32'd3, 1'b1, 32'h1001, 32'd2);
        va[4] = mk(1'b1, 1'b1, 32'd4, 1'b1, 32'h1002, 32'd3);
        va[5] = mk(1'b1, 1'b1, 32'd5, 1'b1, 32'h1003, 32'd4);
        // Backpressure: exactly four requests, head holds, then drain and resume at addr 4.
        vb[0]  = mk(1'b0, 1'b1, 32'd0, 1'b0, 32'h0,    32'd0);
        vb[1]  = mk(1'b0, 1'b1, 32'd1, 1'b0, 32'h0,    32'd0);
        vb[2]  = mk(1'b0, 1'b1, 32'd2, 1'b1, 32'h1000, 32'd1);
        vb[3]  = mk(1'b0, 1'b1, 32'd3, 1'b1, 32'h1000, 32'd1);
        vb[4]  = mk(1'b0, 1'b0, 32'd4, 1'b1, 32'h1000, 32'd1);
        vb[5]  = mk(1'b0, 1'b0, 32'd4, 1'b1, 32'h1000, 32'd1);
        vb[6]  = mk(1'b1, 1'b0, 32'd4, 1'b1, 32'h1000, 32'd1);
        vb[7]  = mk(1'b1, 1'b1, 32'd4, 1'b1, 32'h1001, 32'd2);
        vb[8]  = mk(1'b1, 1'b1, 32'd5, 1'b1, 32'h1002, 32'd3);
        vb[9]  = mk(1'b1, 1'b1, 32'd6, 1'b1, 32'h1003, 32'd4);
        vb[10] = mk(1'b1, 1'b1, 32'd7, 1'b1, 32'h1004, 32'd5);

        // Reset state.
        RN = 1'b0;
        idle_inputs();
        #1;
        check("rst_req",  32'(bus.imem_req),  32'd0);
        check("rst_addr", bus.imem_addr,      32'd0);
        check("rst_vld",  32'(bus.if_valid),  32'd0);
        check("rst_ir",   bus.if_ir,          32'd0);
        check("rst_npc",  bus.if_npc,         32'd0);
        check("rst_err",  32'(bus.fetch_err), 32'd0);

        do_reset();
        for (int i = 0; i < 6; i++) run_vec(va[i], "stream", i);

        do_reset();
        for (int i = 0; i < 11; i++) run_vec(vb[i], "bp", i);
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect at cycle 6 to word 25.
        do_reset();
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'd25, 1'b0);
        check("br_vld_r",  32'(s_vld), 32'd0);
        check("br_req_r",  32'(s_req), 32'd0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("br_req_r1",  32'(s_req), 32'd1);
        check("br_addr_r1", s_addr,     32'd25);
        check("br_vld_r1",  32'(s_vld), 32'd0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("br_vld_r2",  32'(s_vld), 32'd0);
        check("br_addr_r2", s_addr,     32'd26);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("br_vld_r3",  32'(s_vld), 32'd1);
        check("br_ir_r3",   s_ir,       32'h1019);
        check("br_npc_r3",  s_npc,      32'd26);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Full queue, drain one, then push and pop in the same cycle.
        do_reset();
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("pp_req_c6", 32'(s_req), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("pp_req_c7",  32'(s_req), 32'd1);
        check("pp_addr_c7", s_addr,     32'd4);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("pp_req_c8",   32'(s_req),     32'd0);
        check("pp_ir_c8",    s_ir,           32'h1001);
        check("pp_count_c8", 32'(dut.count), 32'd3);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("pp_count_c9", 32'(dut.count), 32'd3);
        check("pp_req_c9",   32'(s_req),     32'd1);
        check("pp_addr_c9",  s_addr,         32'd5);
        check("pp_ir_c9",    s_ir,           32'h1002);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("pp_req_c10", 32'(s_req), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("pp_count_c11", 32'(dut.count), 32'd4);
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // PC wrap at the top of the address space.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        check("wrap_vld_r", 32'(s_vld), 32'd0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("wrap_req_r1",  32'(s_req), 32'd1);
        check("wrap_addr_r1", s_addr,     32'hFFFF_FFFF);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("wrap_req_r2",  32'(s_req), 32'd1);
        check("wrap_addr_r2", s_addr,     32'd0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("wrap_vld_r3", 32'(s_vld), 32'd1);
        check("wrap_ir_r3",  s_ir,       32'h0000_0FFF);
        check("wrap_npc_r3", s_npc,      32'd0);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Spurious response with nothing outstanding.
        do_reset();
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("spur_err_before", 32'(s_err), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("spur_err_set", 32'(s_err),      32'd1);
        check("spur_count",   32'(dut.count),  32'd4);
        check("spur_ir",      s_ir,            32'h1000);
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("spur_err_hold", 32'(s_err), 32'd1);
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("spur_err_hold2", 32'(s_err), 32'd1);

        // Asynchronous reset mid-stream: outputs drop immediately.
        RN = 1'b0;
        #1;
        check("mid_rst_req", 32'(bus.imem_req),  32'd0);
        check("mid_rst_vld", 32'(bus.if_valid),  32'd0);
        check("mid_rst_ir",  bus.if_ir,          32'd0);
        check("mid_rst_npc", bus.if_npc,         32'd0);
        check("mid_rst_err", 32'(bus.fetch_err), 32'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        RN = 1'b1;
        // A stale response in the first cycle after release must be ignored silently.
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("rel_req_c0",  32'(s_req), 32'd1);
        check("rel_addr_c0", s_addr,     32'd0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("rel_err_c1", 32'(s_err), 32'd0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("rel_vld_c2", 32'(s_vld), 32'd1);
        check("rel_ir_c2",  s_ir,       32'h1000);
        check("rel_npc_c2", s_npc,      32'd1);
        check("rel_err_c2", 32'(s_err), 32'd0);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
